reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameters: XLEN, default 32, data width; NREG, default 32, register count (power of 2); NRD, default 2, read ports; NWR, default 2, write ports; SP_IDX, default 2, stack-pointer index; SP_INIT, default 65536, stack-pointer reset value; BYPASS, default 1, write-to-read forwarding enable.
REQ-002 Derived AW = log2(NREG).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rd_addr_i  in  NRD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-006 rd_data_o  out  NRD*XLEN  packed read data.
REQ-007 rd_busy_o  out  NRD  per-port scoreboard busy flag for the addressed register.
REQ-008 wr_en_i  in  NWR  per-port write enable.
REQ-009 wr_addr_i  in  NWR*AW  packed write addresses.
REQ-010 wr_data_i  in  NWR*XLEN  packed write data.
REQ-011 iss_en_i  in  1  issue strobe; marks iss_rd_i pending.
REQ-012 iss_rd_i  in  AW  destination register of the issuing instruction.
REQ-013 flush_i  in  1  clears all pending marks.
REQ-014 busy_vec_o  out  NREG  full scoreboard vector.

Function
REQ-015 Reads SHALL be combinational: rd_data_o[k] = regs[rd_addr_i[k]], zero latency.
REQ-016 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-017 Writes SHALL commit on the rising clk edge when wr_en_i[j]=1.
REQ-018 If several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-019 With BYPASS=1, a read whose address matches an enabled write (nonzero address) in the same cycle SHALL return that write's data, highest-index write port winning; with BYPASS=0 it SHALL return the old value.
REQ-020 Scoreboard: iss_en_i=1 SHALL set busy[iss_rd_i] at the next edge, except for address 0.
REQ-021 Any enabled write to register r SHALL clear busy[r] at the next edge.
REQ-022 Issue and write to the same register in the same cycle: busy SHALL end set (issue wins).
REQ-023 flush_i=1 SHALL clear all busy bits at the next edge; an issue in the same cycle SHALL still set its bit; register contents SHALL be unaffected.
REQ-024 rd_busy_o[k] = busy[rd_addr_i[k]], with BYPASS=1 forced to 0 when a same-cycle write to that address is forwarded; busy[0] SHALL always be 0.

Reset
REQ-025 rst_n low SHALL immediately clear all registers to 0 except regs[SP_IDX] = SP_INIT, and clear all busy bits.
REQ-026 Reset asserted mid-operation SHALL discard any write or issue in that cycle; first write after deassertion takes effect at the first rising edge with rst_n high.
REQ-027 During reset, rd_data_o SHALL reflect reset values (0, or SP_INIT at SP_IDX); rd_busy_o and busy_vec_o SHALL be 0.

Structure
REQ-028 Shared package rf_pkg SHALL hold the default XLEN, NREG, SP_IDX, SP_INIT constants and the ABI register-index constants.
REQ-029 One sub-module, rf_scoreboard, SHALL hold the busy vector and its set/clear/flush logic; storage, write arbitration and bypass muxes stay in reg_file_sb.

Verification
REQ-030 Reset: pulse rst_n low -> read x2 = 65536, x1 = 0, x31 = 0, busy_vec_o = 0.
REQ-031 Write/bypass: wr port0 x5 = 0xDEADBEEF, rd port0 addr 5 same cycle -> 0xDEADBEEF (BYPASS=1), old value 0 (BYPASS=0); next cycle 0xDEADBEEF either way.
REQ-032 x0 and port conflict: port0 writes x0 = 0x1234 -> x0 reads 0; ports 0 and 1 write x7 = 0x11 and 0x22 -> x7 = 0x22.
REQ-033 Scoreboard: issue x9 -> busy_vec_o[9] = 1 next cycle; write x9 = 0x55 -> read 0x55 with rd_busy_o = 0 in the write cycle, busy bit 0 next cycle; issue and write x9 together -> busy stays 1.
REQ-034 Flush: issue x3, x4 over two cycles, then flush_i together with issue x6 -> busy_vec_o has only bit 6 set, x3 and x4 data unchanged.
REQ-035 Async reset mid-write: assert rst_n low between edges during a write to x10 = 0xAA -> x10 reads 0 immediately and after deassertion.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// stack-pointer reset value and RISC-V ABI register indices.
package rf_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREG_DEF    = 32;
    localparam int SP_IDX_DEF  = 2;
    localparam int SP_INIT_DEF = 65536;

    // ABI register indices
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;
    localparam int REG_TP   = 4;
    localparam int REG_T0   = 5;
    localparam int REG_T1   = 6;
    localparam int REG_T2   = 7;
    localparam int REG_S0   = 8;
    localparam int REG_S1   = 9;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared by a write to that register or by a flush. Issue beats both.
module rf_scoreboard
#(
    parameter int NREG = 32,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic              flush_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: flush, then write clears, then issue set; x0 never busy
    always_comb begin
        busy_d = flush_i ? '0 : busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with x0 hard-wired to zero, a stack pointer
// reset value, optional write-to-read forwarding and a pending-write
// scoreboard (rf_scoreboard).
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int SP_IDX  = SP_IDX_DEF,
    parameter int SP_INIT = SP_INIT_DEF,
    parameter bit BYPASS  = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i,
    output logic [NREG-1:0]     busy_vec_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;

    rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_en_i  (iss_en_i),
        .iss_rd_i  (iss_rd_i),
        .flush_i   (flush_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .busy_o    (busy)
    );

    assign busy_vec_o = busy;

    // Write arbitration: ports applied in index order so the highest wins;
    // writes to x0 are dropped
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    // Register storage; reset loads zeros except the stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: stored value, overridden by a same-cycle write when
    // forwarding is on; forwarding is suppressed while in reset so reads
    // show reset values
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] data;
            logic            fwd;
            ra   = rd_addr_i[k*AW +: AW];
            data = (ra == '0) ? '0 : regs_q[ra];
            fwd  = 1'b0;
            if (BYPASS && rst_n) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (ra != '0) && (wr_addr_i[j*AW +: AW] == ra)) begin
                        data = wr_data_i[j*XLEN +: XLEN];
                        fwd  = 1'b1;
                    end
                end
            end
            rd_data_o[k*XLEN +: XLEN] = data;
            rd_busy_o[k]              = busy[ra] & ~fwd;
        end
    end

endmodule
